// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch buffer: sequential word fetch over a req/gnt/rvalid memory port,
// one transaction outstanding, results queued in a small FIFO drained by the core.
module instr_fetch_buffer #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

  state_e                state_q;
  logic                  req_q;
  logic                  discard_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [ADDR_WIDTH-1:0] fpc_q;
  logic [ADDR_WIDTH-1:0] tag_q;

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       cnt_q;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] branch_tgt;

  assign branch_tgt = branch_addr_i & ~ADDR_WIDTH'(3);

  assign valid_o = (cnt_q != '0);
  assign rdata_o = data_mem_q[rd_ptr_q];
  assign addr_o  = addr_mem_q[rd_ptr_q];

  assign instr_req_o  = req_q;
  assign instr_addr_o = req_addr_q;

  // Only one transaction is ever in flight and it completes before the next issue,
  // so cnt alone covers the reserved slot when we are idle.
  assign issue = (state_q == StIdle) && fetch_en_i && !branch_i && (cnt_q < CntW'(DEPTH));
  assign push  = (state_q == StWaitRvalid) && instr_rvalid_i && !discard_q && !branch_i;
  assign pop   = valid_o && ready_i && !branch_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      req_addr_q <= BOOT_ADDR;
      fpc_q      <= BOOT_ADDR;
      tag_q      <= BOOT_ADDR;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            state_q    <= StWaitGnt;
            req_q      <= 1'b1;
            req_addr_q <= fpc_q;
          end
        end
        StWaitGnt: begin
          if (instr_gnt_i) begin
            state_q <= StWaitRvalid;
            req_q   <= 1'b0;
            tag_q   <= req_addr_q;
            // A discarded fetch must not advance past the redirect target.
            if (!discard_q) fpc_q <= fpc_q + ADDR_WIDTH'(4);
          end
        end
        StWaitRvalid: begin
          if (instr_rvalid_i) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (branch_i) begin
        fpc_q <= branch_tgt;
        if ((state_q == StWaitGnt) || ((state_q == StWaitRvalid) && !instr_rvalid_i)) begin
          discard_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (branch_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        addr_mem_q[wr_ptr_q] <= tag_q;
        data_mem_q[wr_ptr_q] <= instr_rdata_i;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomised-latency bench for instr_fetch_buffer: a bench-side memory responder, a
// queue-based reference model compared every cycle, and directed literal scenarios.
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  BOOT  = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic        branch_i;
  logic [7:0]  branch_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [7:0]  addr_o;
  logic        instr_req_o;
  logic [7:0]  instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  always #5 clk = ~clk;

  instr_fetch_buffer #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .BOOT_ADDR (BOOT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  logic [31:0] imem [64];

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model state
  ent_t       q[$];
  ent_t       delivered[$];
  logic [7:0] req_log[$];
  bit         m_busy, m_granted, m_dropped, m_req;
  logic [7:0] m_next, m_txn;
  int         grant_cnt = 0;

  initial begin
    int qs;
    m_busy = 0; m_granted = 0; m_dropped = 0; m_req = 0; m_next = BOOT; m_txn = BOOT;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_busy = 0; m_granted = 0; m_dropped = 0; m_req = 0; m_next = BOOT; m_txn = BOOT;
      end else begin
        qs = q.size();
        if (branch_i) begin
          q.delete();
        end else begin
          if (qs != 0 && ready_i) begin
            delivered.push_back(q[0]);
            void'(q.pop_front());
          end
          if (m_busy && m_granted && instr_rvalid_i && !m_dropped)
            q.push_back({m_txn, instr_rdata_i});
          if (q.size() > int'(DEPTH)) check_eq("fifo_overflow", 32'(q.size()), DEPTH);
        end
        // A transaction touched by any redirect is dropped
        if (m_busy) begin
          if (branch_i) m_dropped = 1;
          if (m_granted && instr_rvalid_i) begin
            m_busy = 0;
          end else if (!m_granted && instr_gnt_i) begin
            m_granted = 1;
            m_req     = 0;
            grant_cnt++;
            if (!m_dropped) m_next = m_txn + 8'd4;
          end
        end else if (fetch_en_i && !branch_i && qs < int'(DEPTH)) begin
          m_busy = 1; m_granted = 0; m_dropped = 0; m_req = 1;
          m_txn  = m_next;
          req_log.push_back(m_next);
        end
        if (branch_i) m_next = branch_addr_i & 8'hFC;
      end
    end
  end

  // Compare DUT outputs against the model on every non-reset cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_eq("req", 32'(instr_req_o), 32'(m_req));
        if (m_req) check_eq("req_addr", 32'(instr_addr_o), 32'(m_txn));
        check_eq("valid", 32'(valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
          check_eq("head_data", rdata_o, q[0].d);
          check_eq("head_addr", 32'(addr_o), 32'(q[0].a));
        end
      end
    end
  end

  // Memory responder with random gnt/rvalid latency
  int         ms = 0, mw = 0, rv_min = 0;
  logic [7:0] ma;
  initial begin
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; ma = '0;
    forever begin
      @(posedge clk);
      #1;
      instr_gnt_i    = 0;
      instr_rvalid_i = 0;
      instr_rdata_i  = $urandom;
      if (rst) begin
        ms = 0;
      end else if (ms == 2) begin
        if (mw == 0) begin
          instr_rvalid_i = 1;
          instr_rdata_i  = imem[ma[7:2]];
          ms             = 0;
        end else mw--;
      end else begin
        if (ms == 0 && instr_req_o) begin
          mw = $urandom_range(0, 2);
          ms = 1;
        end
        if (ms == 1) begin
          if (mw == 0) begin
            instr_gnt_i = 1;
            ma          = instr_addr_o;
            ms          = 2;
            mw          = rv_min + $urandom_range(0, 2);
          end else mw--;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deliv(input int n, input string name);
    int b = 0;
    while (delivered.size() < n && b < 400) begin step(); b++; end
    if (delivered.size() < n) check_eq({name, "_timeout"}, 32'(delivered.size()), 32'(n));
  endtask

  task automatic wait_reqs(input int n, input string name);
    int b = 0;
    while (req_log.size() < n && b < 400) begin step(); b++; end
    if (req_log.size() < n) check_eq({name, "_timeout"}, 32'(req_log.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((m_busy || q.size() != 0) && b < 400) begin step(); b++; end
    if (m_busy || q.size() != 0) check_eq("idle_timeout", 32'(q.size()), 0);
  endtask

  initial begin
    logic [31:0] exp_d [4];
    logic [7:0]  exp_w [4];
    int d0, r0, g0, g1, b;

    for (int i = 0; i < 64; i++) imem[i] = 32'hA500_0000 | 32'(i * 4);
    imem[0]  = 32'h1000_0113;
    imem[1]  = 32'h0010_0093;
    imem[2]  = 32'h4011_01B3;
    imem[3]  = 32'h0000_2283;
    imem[18] = 32'h0262_83B3;
    imem[19] = 32'h0253_B433;
    exp_d[0] = 32'h1000_0113; exp_d[1] = 32'h0010_0093;
    exp_d[2] = 32'h4011_01B3; exp_d[3] = 32'h0000_2283;

    rst = 1; fetch_en_i = 1; branch_i = 0; branch_addr_i = '0; ready_i = 1;
    repeat (3) begin
      @(negedge clk);
      check_eq("req_during_reset", 32'(instr_req_o), 0);
    end
    check_eq("rst_instr_addr", 32'(instr_addr_o), 32'(BOOT));
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_addr", 32'(addr_o), 0);
    step();
    rst = 0;

    // Sequential fetch from boot
    wait_deliv(4, "seq");
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_data", delivered[i].d, exp_d[i]);
      check_eq("seq_addr", 32'(delivered[i].a), 32'(i * 4));
    end

    // Backpressure from a clean state at 0x00
    fetch_en_i = 0;
    wait_idle();
    branch_i = 1; branch_addr_i = 8'h00;
    step();
    branch_i = 0; ready_i = 0; fetch_en_i = 1;
    g0 = grant_cnt;
    repeat (60) step();
    check_eq("bp_grants", 32'(grant_cnt - g0), 4);
    @(negedge clk);
    check_eq("bp_req_low", 32'(instr_req_o), 0);
    step();
    ready_i = 1;
    d0 = delivered.size(); g1 = grant_cnt;
    step();
    ready_i = 0;
    check_eq("bp_pop_addr", 32'(delivered[d0].a), 0);
    check_eq("bp_pop_data", delivered[d0].d, 32'h1000_0113);
    repeat (40) step();
    check_eq("bp_regrant", 32'(grant_cnt - g1), 1);
    ready_i = 1;

    // Branch while waiting for rvalid
    rv_min = 1;
    b = 0;
    do begin @(posedge clk); b++; end while (!instr_gnt_i && b < 200);
    check_eq("br_gnt_seen", 32'(instr_gnt_i), 1);
    #1;
    branch_i = 1; branch_addr_i = 8'h4B;
    step();
    branch_i = 0; rv_min = 0;
    d0 = delivered.size();
    @(negedge clk);
    check_eq("br_valid_after", 32'(valid_o), 0);
    b = 0;
    do begin @(posedge clk); b++; end while (!instr_rvalid_i && b < 50);
    @(negedge clk);
    check_eq("br_dropped_valid", 32'(valid_o), 0);
    wait_deliv(d0 + 2, "br");
    check_eq("br_d0_addr", 32'(delivered[d0].a), 32'h48);
    check_eq("br_d0_data", delivered[d0].d, 32'h0262_83B3);
    check_eq("br_d1_addr", 32'(delivered[d0 + 1].a), 32'h4C);
    check_eq("br_d1_data", delivered[d0 + 1].d, 32'h0253_B433);

    // Branch coincident with rvalid and a pop
    ready_i = 0;
    b = 0;
    while (q.size() < 2 && b < 200) begin step(); b++; end
    b = 0;
    do begin @(posedge clk); #2; b++; end while (!instr_rvalid_i && b < 50);
    check_eq("co_valid_before", 32'(valid_o), 1);
    branch_i = 1; branch_addr_i = 8'h20; ready_i = 1;
    r0 = req_log.size();
    step();
    branch_i = 0; ready_i = 0;
    @(negedge clk);
    check_eq("co_valid_after", 32'(valid_o), 0);
    wait_reqs(r0 + 1, "co");
    check_eq("co_first_req", 32'(req_log[r0]), 32'h20);
    ready_i = 1;
    d0 = delivered.size();
    wait_deliv(d0 + 1, "co");
    check_eq("co_deliv_addr", 32'(delivered[d0].a), 32'h20);
    check_eq("co_deliv_data", delivered[d0].d, 32'hA500_0020);

    // Address wrap-around
    branch_i = 1; branch_addr_i = 8'hF8;
    step();
    branch_i = 0;
    r0 = req_log.size();
    wait_reqs(r0 + 4, "wrap");
    exp_w[0] = 8'hF8; exp_w[1] = 8'hFC; exp_w[2] = 8'h00; exp_w[3] = 8'h04;
    for (int i = 0; i < 4; i++)
      check_eq("wrap_addr", 32'(req_log[r0 + i]), 32'(exp_w[i]));

    // Reset while a request is waiting for grant
    b = 0;
    do begin @(posedge clk); #2; b++; end while (!instr_req_o && b < 50);
    rst = 1;
    #1;
    check_eq("mrst_req", 32'(instr_req_o), 0);
    check_eq("mrst_instr_addr", 32'(instr_addr_o), 32'(BOOT));
    check_eq("mrst_valid", 32'(valid_o), 0);
    check_eq("mrst_rdata", rdata_o, 0);
    check_eq("mrst_addr", 32'(addr_o), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 0;
    r0 = req_log.size();
    d0 = delivered.size();
    wait_reqs(r0 + 1, "mrst");
    check_eq("mrst_first_req", 32'(req_log[r0]), 32'(BOOT));
    wait_deliv(d0 + 1, "mrst");
    check_eq("mrst_deliv_addr", 32'(delivered[d0].a), 32'(BOOT));
    check_eq("mrst_deliv_data", delivered[d0].d, 32'h1000_0113);

    repeat (20) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
